// File: rtl/pipe_addsub_stream.sv
// Pipelined N-bit adder/subtractor with a valid/ready stream interface.
// Each stage resolves one SEG-bit slice; the carry ripples stage to stage through registers.
module pipe_addsub_stream #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int SEG = N / STAGES;

  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] cy_q;
  logic [N-1:0]      res_q [STAGES];
  logic [N-1:0]      opa_q [STAGES];
  logic [N-1:0]      opb_q [STAGES];
  logic              ovf_q;
  logic [STAGES-1:0] rdy_s;

  // A stage may load when any stage from it to the output has a bubble, or the sink drains.
  for (genvar k = 0; k < STAGES; k++) begin : g_ready
    assign rdy_s[k] = out_ready | ~(&vld_q[STAGES-1:k]);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic         src_vld_s;
    logic         src_cy_s;
    logic [N-1:0] src_a_s;
    logic [N-1:0] src_b_s;
    logic [N-1:0] src_res_s;
    logic [SEG:0] add_s;
    logic [N-1:0] res_d;
    logic         vld_d;

    // Stage 0 takes the effective operand B and carry-in; later stages take the previous register.
    if (k == 0) begin : g_src_in
      assign src_vld_s = in_valid;
      assign src_a_s   = a;
      assign src_b_s   = sub ? ~b : b;
      assign src_cy_s  = sub ? ~cin : cin;
      assign src_res_s = '0;
    end else begin : g_src_prev
      assign src_vld_s = vld_q[k-1];
      assign src_a_s   = opa_q[k-1];
      assign src_b_s   = opb_q[k-1];
      assign src_cy_s  = cy_q[k-1];
      assign src_res_s = res_q[k-1];
    end

    // Slice adder for this stage, merged into the already-resolved lower bits.
    always_comb begin
      add_s = {1'b0, src_a_s[k*SEG +: SEG]} + {1'b0, src_b_s[k*SEG +: SEG]}
            + {{SEG{1'b0}}, src_cy_s};
      res_d = src_res_s;
      res_d[k*SEG +: SEG] = add_s[SEG-1:0];
    end

    assign vld_d = rdy_s[k] ? src_vld_s : vld_q[k];

    // Stage register: payload loads only on a real transfer, so bubbles leave stale data behind.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        res_q[k] <= '0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end else begin
        vld_q[k] <= vld_d;
        if (rdy_s[k] && src_vld_s) begin
          cy_q[k]  <= add_s[SEG];
          res_q[k] <= res_d;
          opa_q[k] <= src_a_s;
          opb_q[k] <= src_b_s;
        end else begin
          cy_q[k]  <= cy_q[k];
          res_q[k] <= res_q[k];
          opa_q[k] <= opa_q[k];
          opb_q[k] <= opb_q[k];
        end
      end
    end

    if (k == STAGES - 1) begin : g_ovf
      // Signed overflow is only knowable once the top slice resolves the result MSB.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (rdy_s[k] && src_vld_s) begin
          ovf_q <= (src_a_s[N-1] == src_b_s[N-1]) && (res_d[N-1] != src_a_s[N-1]);
        end else begin
          ovf_q <= ovf_q;
        end
      end
    end
  end

  assign in_ready  = rdy_s[0];
  assign out_valid = vld_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign cout      = cy_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_addsub_stream.sv
// Bench for pipe_addsub_stream at N=16, STAGES=4: directed vector table with latency checks,
// plus streaming, backpressure and mid-flight reset sequences scored against a reference model.
module tb_pipe_addsub_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  int cyc    = 0;

  logic [17:0] sb [$];
  int          out_cyc [$];
  logic [17:0] exp_e;
  logic        hold_q = 1'b0;
  logic [18:0] hold_val;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        c;
    logic        o;
  } vec_t;

  vec_t vecs [8];

  pipe_addsub_stream #(.N(16), .STAGES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic ms, input logic mc);
    logic [15:0] ob;
    logic        ec;
    logic [16:0] r;
    logic        o;
    ob = ms ? ~mb : mb;
    ec = ms ? ~mc : mc;
    r  = {1'b0, ma} + {1'b0, ob} + {16'd0, ec};
    o  = (ma[15] == ob[15]) && (r[15] != ma[15]);
    return {r[15:0], r[16], o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on drain, and check hold during stalls.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_q) chk("stall_hold", {13'd0, out_valid, sum, cout, ovf}, {13'd0, hold_val});
      hold_q   = out_valid && !out_ready;
      hold_val = {out_valid, sum, cout, ovf};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", {14'd0, sum, cout, ovf}, 32'hFFFF_FFFF);
        end else begin
          exp_e = sb.pop_front();
          chk("sb_result", {14'd0, sum, cout, ovf}, {14'd0, exp_e});
          n_out++;
          out_cyc.push_back(cyc);
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, sub, cin));
    end else begin
      hold_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                         input logic vc, output logic [15:0] rs, output logic rc,
                         output logic ro, output int edges);
    in_valid = 1'b1; a = va; b = vb; sub = vs; cin = vc;
    tick();
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 20) begin
      tick();
      edges++;
    end
    rs = sum; rc = cout; ro = ovf;
    tick();
  endtask

  initial begin
    logic [15:0] rs;
    logic        rc;
    logic        ro;
    int          edges;
    int          base;
    int          sent;
    int          stall_acc;
    logic        acc;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000; sub = 1'b0; cin = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_sum", {16'd0, sum}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Directed vectors with latency measurement.
    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, rs, rc, ro, edges);
      chk($sformatf("vec%0d_latency", i), edges, 32'd4);
      chk($sformatf("vec%0d_sum", i), {16'd0, rs}, {16'd0, vecs[i].s});
      chk($sformatf("vec%0d_cout", i), {31'd0, rc}, {31'd0, vecs[i].c});
      chk($sformatf("vec%0d_ovf", i), {31'd0, ro}, {31'd0, vecs[i].o});
    end
    repeat (4) tick();

    // Back-to-back stream of 20 random beats.
    base = n_out;
    out_cyc.delete();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      #1;
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40 && n_out < base + 20; i++) tick();
    chk("b2b_count", n_out - base, 32'd20);
    if (out_cyc.size() == 20) chk("b2b_throughput", out_cyc[19] - out_cyc[0], 32'd19);
    else chk("b2b_out_cycles", out_cyc.size(), 32'd20);

    // Backpressure: 10 beats with out_ready low for cycles 3..8.
    base = n_out;
    sent = 0;
    stall_acc = 0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    for (int c = 0; c < 100 && sent < 10; c++) begin
      out_ready = !(c >= 3 && c < 9);
      in_valid = 1'b1;
      #2;
      acc = in_ready;
      if (!out_ready && acc) stall_acc++;
      if (c == 8) chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_stall_accepts_le4", {31'd0, stall_acc <= 4}, 32'd1);
    for (int i = 0; i < 40 && n_out < base + 10; i++) tick();
    chk("bp_count", n_out - base, 32'd10);
    chk("bp_sb_empty", sb.size(), 32'd0);

    // Reset with 3 beats in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    base = n_out;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (8) tick();
    chk("midrst_no_stale", n_out - base, 32'd0);
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, edges);
    chk("midrst_latency", edges, 32'd4);
    chk("midrst_sum_after", {16'd0, rs}, 32'h0000_8000);
    chk("midrst_ovf_after", {31'd0, ro}, 32'd1);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
